// File: rtl/vcsr_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : vcsr_access_ctrl
// Purpose  : Vector CSR access front end. Sequences vsetvli/vsetvl writes into
//            the vector CSR block and returns vl or a CSR read as the result.
// Revision : 1.0 - initial release
// ============================================================================
module vcsr_access_ctrl #(
    parameter int VLENB = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        apu_req,
    output logic        apu_gnt,
    input  logic [1:0]  apu_op,
    input  logic [31:0] apu_rs1_val,
    input  logic [31:0] apu_rs2_val,
    input  logic [4:0]  apu_zimm,
    input  logic        apu_rs1_zero,
    input  logic        apu_rd_zero,
    input  logic [11:0] apu_csr_addr,
    output logic        apu_rvalid,
    output logic [31:0] apu_result,
    output logic        apu_illegal,
    input  logic        vu_busy,
    output logic        csr_write,
    output logic [31:0] csr_avl,
    output logic [4:0]  csr_vtype,
    output logic        csr_preserve_vl,
    output logic        csr_set_vl_max,
    input  logic [4:0]  csr_vl,
    input  logic [1:0]  csr_vsew,
    input  logic [1:0]  csr_vlmul,
    input  logic        csr_vxsat
);

    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_WRITE   = 2'd1;
    localparam logic [1:0] c_ST_WAIT    = 2'd2;
    localparam logic [1:0] c_ST_RESP    = 2'd3;

    localparam logic [1:0] c_OP_VSETVLI = 2'd0;
    localparam logic [1:0] c_OP_VSETVL  = 2'd1;
    localparam logic [1:0] c_OP_CSRRD   = 2'd2;

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic        w_accept;
    logic        w_is_vset;
    logic        w_vset_illegal;
    logic [31:0] w_csr_rdata;
    logic        w_csr_bad;
    logic [31:0] r_result;
    logic        r_illegal;
    logic [31:0] r_avl;
    logic [4:0]  r_vtype;
    logic        r_preserve;
    logic        r_set_max;

    assign apu_gnt        = (r_state == c_ST_IDLE) & ~vu_busy;
    assign w_accept       = apu_req & apu_gnt;
    assign w_is_vset      = (apu_op == c_OP_VSETVLI) | (apu_op == c_OP_VSETVL);
    // vtype fields beyond vsew/vlmul are reserved, so any of bits 31:4 set is illegal
    assign w_vset_illegal = (apu_op == c_OP_VSETVL) & (apu_rs2_val[31:4] != 28'd0);

    assign apu_rvalid      = (r_state == c_ST_RESP);
    assign apu_result      = r_result;
    assign apu_illegal     = r_illegal;
    assign csr_write       = (r_state == c_ST_WRITE);
    assign csr_avl         = r_avl;
    assign csr_vtype       = r_vtype;
    assign csr_preserve_vl = r_preserve;
    assign csr_set_vl_max  = r_set_max;

    always_comb begin
        w_csr_rdata = 32'd0;
        w_csr_bad   = 1'b0;
        case (apu_csr_addr)
            12'h009: w_csr_rdata = {31'd0, csr_vxsat};
            12'h00A: w_csr_rdata = 32'd0;
            12'hC20: w_csr_rdata = {27'd0, csr_vl};
            12'hC21: w_csr_rdata = {27'd0, 1'b0, csr_vsew, csr_vlmul};
            12'hC22: w_csr_rdata = 32'(VLENB);
            default: w_csr_bad   = 1'b1;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_accept) begin
                    if (w_is_vset && !w_vset_illegal) begin
                        w_state_nxt = c_ST_WRITE;
                    end else begin
                        w_state_nxt = c_ST_RESP;
                    end
                end
            end
            c_ST_WRITE: w_state_nxt = c_ST_WAIT;
            c_ST_WAIT:  w_state_nxt = c_ST_RESP;
            c_ST_RESP:  w_state_nxt = c_ST_IDLE;
            default:    w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_result   <= 32'd0;
            r_illegal  <= 1'b0;
            r_avl      <= 32'd0;
            r_vtype    <= 5'd0;
            r_preserve <= 1'b0;
            r_set_max  <= 1'b0;
        end else begin
            if (r_state == c_ST_RESP) begin
                r_illegal <= 1'b0;
            end
            // vl has already been updated by the write that ended the WRITE state
            if (r_state == c_ST_WAIT) begin
                r_result <= {27'd0, csr_vl};
            end
            if (w_accept) begin
                if (w_is_vset) begin
                    r_avl      <= apu_rs1_val;
                    r_vtype    <= (apu_op == c_OP_VSETVLI) ? apu_zimm : apu_rs2_val[4:0];
                    r_preserve <= apu_rs1_zero & apu_rd_zero;
                    r_set_max  <= apu_rs1_zero & ~apu_rd_zero;
                    if (w_vset_illegal) begin
                        r_result  <= 32'd0;
                        r_illegal <= 1'b1;
                    end
                end else if (apu_op == c_OP_CSRRD) begin
                    r_result  <= w_csr_rdata;
                    r_illegal <= w_csr_bad;
                end else begin
                    r_result  <= 32'd0;
                    r_illegal <= 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vcsr_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_vcsr_access_ctrl
// Purpose  : Scoreboard bench for vcsr_access_ctrl with a vector CSR block
//            model and an instruction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vcsr_access_ctrl;

    localparam int c_VLENB = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        apu_req = 1'b0;
    logic        apu_gnt;
    logic [1:0]  apu_op = 2'd0;
    logic [31:0] apu_rs1_val = 32'd0;
    logic [31:0] apu_rs2_val = 32'd0;
    logic [4:0]  apu_zimm = 5'd0;
    logic        apu_rs1_zero = 1'b0;
    logic        apu_rd_zero = 1'b0;
    logic [11:0] apu_csr_addr = 12'd0;
    logic        apu_rvalid;
    logic [31:0] apu_result;
    logic        apu_illegal;
    logic        vu_busy = 1'b0;
    logic        csr_write;
    logic [31:0] csr_avl;
    logic [4:0]  csr_vtype;
    logic        csr_preserve_vl;
    logic        csr_set_vl_max;
    logic [4:0]  env_vl;
    logic [1:0]  env_vsew;
    logic [1:0]  env_vlmul;
    logic        vxsat = 1'b0;

    vcsr_access_ctrl #(.VLENB(c_VLENB)) dut (
        .clk(clk), .reset(reset),
        .apu_req(apu_req), .apu_gnt(apu_gnt), .apu_op(apu_op),
        .apu_rs1_val(apu_rs1_val), .apu_rs2_val(apu_rs2_val), .apu_zimm(apu_zimm),
        .apu_rs1_zero(apu_rs1_zero), .apu_rd_zero(apu_rd_zero), .apu_csr_addr(apu_csr_addr),
        .apu_rvalid(apu_rvalid), .apu_result(apu_result), .apu_illegal(apu_illegal),
        .vu_busy(vu_busy), .csr_write(csr_write), .csr_avl(csr_avl), .csr_vtype(csr_vtype),
        .csr_preserve_vl(csr_preserve_vl), .csr_set_vl_max(csr_set_vl_max),
        .csr_vl(env_vl), .csr_vsew(env_vsew), .csr_vlmul(env_vlmul), .csr_vxsat(vxsat)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s @cyc %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // VLMAX = VLEN / SEW * LMUL, clipped to what a 5-bit vl can hold
    function automatic int vlmax_of(input int sew, input int lmul);
        int v;
        v = ((c_VLENB * 8) >> (3 + sew)) << lmul;
        return (v > 31) ? 31 : v;
    endfunction

    // Vector CSR block environment: vl/vtype update on the write strobe
    always @(posedge clk) begin
        if (reset) begin
            env_vl    <= 5'd0;
            env_vsew  <= 2'd0;
            env_vlmul <= 2'd0;
        end else if (csr_write) begin
            env_vsew  <= csr_vtype[3:2];
            env_vlmul <= csr_vtype[1:0];
            if (!csr_preserve_vl) begin
                if (csr_set_vl_max)
                    env_vl <= 5'(vlmax_of(int'(csr_vtype[3:2]), int'(csr_vtype[1:0])));
                else if (csr_avl < 32'(vlmax_of(int'(csr_vtype[3:2]), int'(csr_vtype[1:0]))))
                    env_vl <= csr_avl[4:0];
                else
                    env_vl <= 5'(vlmax_of(int'(csr_vtype[3:2]), int'(csr_vtype[1:0])));
            end
        end
    end

    typedef struct { int cyc; logic [31:0] result; logic illegal; } rsp_t;
    typedef struct { int cyc; logic [31:0] avl; logic [4:0] vtype; logic pres; logic smax; } wr_t;
    rsp_t rsp_q[$];
    wr_t  wr_q[$];

    // Reference architectural state and expected held control values
    int          ref_vl = 0, ref_vsew = 0, ref_vlmul = 0;
    int          idle_from = 0;
    logic [31:0] exp_avl = 32'd0;
    logic [4:0]  exp_vtype = 5'd0;
    logic        exp_pres = 1'b0, exp_smax = 1'b0;

    // Monitor: compares DUT outputs against the queued expectations
    always @(negedge clk) begin
        #1;
        if (!reset) begin
            logic exp_rv, exp_wr;
            rsp_t r;
            wr_t  w;
            exp_rv = (rsp_q.size() > 0) && (rsp_q[0].cyc <= cyc);
            chk("apu_rvalid", apu_rvalid, exp_rv);
            if (apu_rvalid && rsp_q.size() > 0) begin
                r = rsp_q.pop_front();
                chk("rvalid_cycle", cyc, r.cyc);
                chk("apu_result", apu_result, r.result);
                chk("apu_illegal", apu_illegal, r.illegal);
            end else if (!apu_rvalid) begin
                if (exp_rv) void'(rsp_q.pop_front());
                chk("illegal_outside_rvalid", apu_illegal, 1'b0);
            end
            exp_wr = (wr_q.size() > 0) && (wr_q[0].cyc <= cyc);
            chk("csr_write", csr_write, exp_wr);
            if (csr_write && wr_q.size() > 0) begin
                w = wr_q.pop_front();
                chk("write_cycle", cyc, w.cyc);
                chk("write_avl", csr_avl, w.avl);
                chk("write_vtype", csr_vtype, w.vtype);
                chk("write_preserve", csr_preserve_vl, w.pres);
                chk("write_set_max", csr_set_vl_max, w.smax);
            end else if (!csr_write && exp_wr) begin
                void'(wr_q.pop_front());
            end
            chk("hold_avl", csr_avl, exp_avl);
            chk("hold_vtype", csr_vtype, exp_vtype);
            chk("hold_preserve", csr_preserve_vl, exp_pres);
            chk("hold_set_max", csr_set_vl_max, exp_smax);
        end
    end

    // Reference model of one instruction, evaluated at the accept cycle
    task automatic model_accept(input logic [1:0] op, input logic [31:0] rs1, input logic [31:0] rs2,
                                input logic [4:0] zimm, input logic rs1z, input logic rdz,
                                input logic [11:0] addr);
        rsp_t r;
        wr_t  w;
        int   lat, vm;
        logic [4:0] vt;
        r.result = 32'd0;
        r.illegal = 1'b1;
        lat = 1;
        if (op == 2'd0 || op == 2'd1) begin
            vt = (op == 2'd0) ? zimm : rs2[4:0];
            exp_avl = rs1; exp_vtype = vt;
            exp_pres = rs1z && rdz; exp_smax = rs1z && !rdz;
            if (!(op == 2'd1 && rs2 > 32'd15)) begin
                ref_vsew = int'(vt[3:2]); ref_vlmul = int'(vt[1:0]);
                vm = vlmax_of(ref_vsew, ref_vlmul);
                if (!exp_pres) ref_vl = exp_smax ? vm : ((rs1 < 32'(vm)) ? int'(rs1) : vm);
                r.result = 32'(ref_vl); r.illegal = 1'b0; lat = 3;
                w.cyc = cyc + 1; w.avl = rs1; w.vtype = vt; w.pres = exp_pres; w.smax = exp_smax;
                wr_q.push_back(w);
            end
        end else if (op == 2'd2) begin
            r.illegal = 1'b0;
            case (addr)
                12'h009: r.result = 32'(vxsat);
                12'h00A: r.result = 32'd0;
                12'hC20: r.result = 32'(ref_vl);
                12'hC21: r.result = 32'(ref_vsew * 4 + ref_vlmul);
                12'hC22: r.result = 32'(c_VLENB);
                default: r.illegal = 1'b1;
            endcase
        end
        r.cyc = cyc + lat;
        rsp_q.push_back(r);
        idle_from = cyc + lat + 1;
    endtask

    // Hold the request until granted; call at a negedge, returns at the next negedge
    task automatic issue(input logic [1:0] op, input logic [31:0] rs1, input logic [31:0] rs2,
                         input logic [4:0] zimm, input logic rs1z, input logic rdz,
                         input logic [11:0] addr, input bit rand_busy);
        bit done = 0;
        logic eg;
        apu_req = 1'b1; apu_op = op; apu_rs1_val = rs1; apu_rs2_val = rs2; apu_zimm = zimm;
        apu_rs1_zero = rs1z; apu_rd_zero = rdz; apu_csr_addr = addr;
        for (int w = 0; w < 100 && !done; w++) begin
            vu_busy = rand_busy && ($urandom_range(0, 3) == 0);
            vxsat = 1'($urandom_range(0, 1));
            #2;
            eg = (cyc >= idle_from) && !vu_busy;
            chk("apu_gnt", apu_gnt, eg);
            if (eg) begin
                model_accept(op, rs1, rs2, zimm, rs1z, rdz, addr);
                done = 1;
            end
            @(negedge clk);
        end
        chk("grant_timeout", done, 1'b1);
        apu_req = 1'b0; vu_busy = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 20 && cyc < idle_from; i++) @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_rvalid"}, apu_rvalid, 1'b0);
        chk({tag, "_illegal"}, apu_illegal, 1'b0);
        chk({tag, "_result"}, apu_result, 32'd0);
        chk({tag, "_write"}, csr_write, 1'b0);
        chk({tag, "_avl"}, csr_avl, 32'd0);
        chk({tag, "_vtype"}, csr_vtype, 5'd0);
        chk({tag, "_preserve"}, csr_preserve_vl, 1'b0);
        chk({tag, "_set_max"}, csr_set_vl_max, 1'b0);
        chk({tag, "_gnt"}, apu_gnt, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  op;
        logic [31:0] rs1, rs2;
        logic        rs1z, rdz;
        logic [11:0] addr;
        int          sel;

        repeat (3) @(negedge clk);
        #2;
        check_all_zero("reset");
        @(negedge clk);
        reset = 1'b0;
        idle_from = cyc;

        // Directed sequence
        issue(2'd0, 32'd3, 32'd0, 5'b00100, 1'b0, 1'b0, 12'd0, 0);
        wait_idle();
        issue(2'd0, 32'd0, 32'd0, 5'b00010, 1'b1, 1'b0, 12'd0, 0);
        wait_idle();
        issue(2'd0, 32'd7, 32'd0, 5'b00010, 1'b0, 1'b0, 12'd0, 0);
        wait_idle();
        issue(2'd0, 32'd0, 32'd0, 5'b00010, 1'b1, 1'b1, 12'd0, 0);
        wait_idle();
        issue(2'd1, 32'd5, 32'h20, 5'd0, 1'b0, 1'b0, 12'd0, 0);
        issue(2'd2, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 12'hC22, 0);
        issue(2'd0, 32'd1, 32'd0, 5'b00110, 1'b0, 1'b0, 12'd0, 0);
        issue(2'd2, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 12'hC21, 0);
        issue(2'd2, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 12'h123, 0);
        issue(2'd3, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 12'd0, 0);
        wait_idle();

        // Busy blocks the grant while the request is held
        apu_req = 1'b1; apu_op = 2'd2; apu_csr_addr = 12'hC20;
        for (int i = 0; i < 5; i++) begin
            vu_busy = 1'b1;
            #2;
            chk("apu_gnt_busy", apu_gnt, (cyc >= idle_from) && !vu_busy);
            @(negedge clk);
        end
        issue(2'd2, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 12'hC20, 0);
        wait_idle();

        // Reset during WRITE aborts the operation
        issue(2'd0, 32'd9, 32'd0, 5'b00001, 1'b0, 1'b0, 12'd0, 0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        rsp_q.delete(); wr_q.delete();
        ref_vl = 0; ref_vsew = 0; ref_vlmul = 0;
        exp_avl = 32'd0; exp_vtype = 5'd0; exp_pres = 1'b0; exp_smax = 1'b0;
        idle_from = cyc;
        #2;
        check_all_zero("post_reset");
        repeat (5) @(negedge clk);

        // Randomized traffic
        for (int n = 0; n < 300; n++) begin
            op = 2'($urandom_range(0, 3));
            rs1z = ($urandom_range(0, 4) == 0);
            rdz = ($urandom_range(0, 3) == 0);
            rs1 = rs1z ? 32'd0 : (($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 40)));
            rs2 = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 15));
            sel = $urandom_range(0, 5);
            case (sel)
                0: addr = 12'h009;
                1: addr = 12'h00A;
                2: addr = 12'hC20;
                3: addr = 12'hC21;
                4: addr = 12'hC22;
                default: addr = 12'($urandom);
            endcase
            issue(op, rs1, rs2, 5'($urandom), rs1z, rdz, addr, 1);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        for (int i = 0; i < 20 && (rsp_q.size() > 0 || wr_q.size() > 0); i++) @(negedge clk);
        chk("rsp_queue_drained", rsp_q.size(), 32'd0);
        chk("write_queue_drained", wr_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vcsr_access_ctrl.md
Name: vcsr_access_ctrl

Overview:
Front end for the vector CSR block. Accepts vsetvli/vsetvl and vector-CSR read requests from the APU-side issue interface and drives the CSR block's write/AVL/vtype/preserve/set-max controls. After the CSR block updates, it reads back the new vl (or the addressed CSR) and returns it as the instruction result. Sits between the APU request decoder and the vector CSR register block.

Parameters:
VLENB, 4, vector register length in bytes; the value returned for the vlenb CSR read.

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
apu_req  in  1  request valid
apu_gnt  out  1  request accepted this cycle
apu_op  in  2  00 vsetvli, 01 vsetvl, 10 CSR read, 11 reserved
apu_rs1_val  in  32  AVL value
apu_rs2_val  in  32  vtype source for vsetvl
apu_zimm  in  5  vtype immediate for vsetvli
apu_rs1_zero  in  1  rs1 field is x0
apu_rd_zero  in  1  rd field is x0
apu_csr_addr  in  12  CSR address for CSR read
apu_rvalid  out  1  result valid, one-cycle pulse
apu_result  out  32  result data
apu_illegal  out  1  qualifies apu_rvalid; request was illegal
vu_busy  in  1  vector datapath busy; blocks new grants
csr_write  out  1  write strobe to CSR block
csr_avl  out  32  AVL to CSR block
csr_vtype  out  5  vtype to CSR block
csr_preserve_vl  out  1  leave vl unchanged
csr_set_vl_max  out  1  force vl to VLMAX
csr_vl  in  5  current vl
csr_vsew  in  2  current vsew
csr_vlmul  in  2  current vlmul
csr_vxsat  in  1  saturation flag

Behaviour:
- Reset: state IDLE. apu_rvalid, apu_illegal, csr_write, csr_preserve_vl, csr_set_vl_max = 0. apu_result, csr_avl = 0. csr_vtype = 0. A reset in any state aborts the operation: no csr_write and no rvalid are issued afterwards.
- apu_gnt = (state==IDLE) & ~vu_busy. This is combinational. An accept occurs when apu_req & apu_gnt.
- FSM states: IDLE, WRITE, WAIT, RESP.
- IDLE accept, op 00/01:
  - Capture csr_avl = rs1_val.
  - Capture csr_vtype = zimm (op 00) or rs2_val[4:0] (op 01).
  - csr_preserve_vl = rs1_zero & rd_zero.
  - csr_set_vl_max = rs1_zero & ~rd_zero.
  - Next state WRITE.
- vsetvl legality check: if rs2_val[31:5] != 0 or rs2_val[4] = 1, the request is illegal. Skip the CSR write, set result = 0 and illegal = 1, next state RESP.
- WRITE: csr_write = 1 for exactly one cycle, next state WAIT. vl updates on the clock edge that ends WRITE.
- WAIT: register apu_result = {27'b0, csr_vl}, next state RESP.
- IDLE accept, op 10: register result and next state RESP.
  - 0x009 → {31'b0, csr_vxsat}
  - 0x00A → 0
  - 0xC20 → {27'b0, csr_vl}
  - 0xC21 → {27'b0, 1'b0, csr_vsew, csr_vlmul}
  - 0xC22 → VLENB
  - Any other address → result 0, illegal = 1.
- IDLE accept, op 11: result 0, illegal = 1, next state RESP.
- RESP: apu_rvalid = 1 for one cycle, with apu_illegal valid. There is no back-pressure. Next state IDLE. apu_illegal clears when leaving RESP. apu_result holds until the next capture.
- Latency (accept at cycle 0): vsetvl* rvalid at cycle 3; CSR read, illegal, and reserved ops rvalid at cycle 1.
- Back-to-back: a new accept is possible in the cycle after RESP at the earliest.
- csr_avl, csr_vtype, csr_preserve_vl, and csr_set_vl_max hold their captured values until the next vsetvl* accept.
- apu_req while not granted is ignored. The requester holds the request.
- vu_busy asserting after an accept does not stall the FSM.

Test Plan:
- vsetvli, rs1_val=3, zimm=5'b00100 (e16, m1), rd≠0 → csr_write pulse at cycle 1, avl=3; with CSR block VLMAX=2, rvalid at cycle 3 with result 2, illegal 0.
- vsetvli, rs1_zero=1, rd_zero=0, zimm=5'b00010 (e8, m4) → set_vl_max=1, preserve=0; result 16.
- vsetvli, rs1_zero=rd_zero=1 after vl=7 → preserve_vl=1, csr_write pulses once, result 7.
- vsetvl, rs2_val=32'h20 → no csr_write; rvalid at cycle 1 with illegal=1, result 0.
- CSR read 0xC22 → result 4 at cycle 1. CSR read 0xC21 with vsew=01, vlmul=10 → result 6. CSR read 0x123 → illegal=1, result 0.
- vu_busy=1 with apu_req=1 → apu_gnt=0 for 5 cycles, then granted in the cycle busy drops. Reset asserted during WRITE → no rvalid, state IDLE, all outputs zero next cycle.
